// File: rtl/fir_pkg.sv
// Shared FIR definitions: default geometry, sequencer state type, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  localparam int FIR_TAPS_DEF    = 16;
  localparam int FIR_WIDTH_DEF   = 16;
  localparam int FIR_RUN_CNT_W   = 16;

  // Sequencer phases: preload samples, load weights, then stream.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WIND = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } fir_state_t;

  // Width of a counter that indexes 0..taps-1; never narrower than one bit.
  function automatic int tap_cnt_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_sequencer.sv
// Steers one upstream word stream into FIR sample-preload, weight-load and streaming strobes.
// Latency: 1 cycle from accepted word to strobe, sustaining 1 word/cycle.
// Backpressure: s_ready low in IDLE and in any cfg_start cycle; otherwise always ready.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS  = FIR_TAPS_DEF,
  parameter int WIDTH = FIR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     run_stop,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     wind,
  output logic                     load,
  output logic                     in_valid,
  output logic [WIDTH-1:0]         data,
  output logic                     cfg_done,
  output logic [FIR_RUN_CNT_W-1:0] run_count
);

  localparam int                CNT_W    = tap_cnt_width(TAPS);
  localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(TAPS - 1);

  fir_state_t                 r_state;
  logic [CNT_W-1:0]           r_tap;
  logic                       r_wind;
  logic                       r_load;
  logic                       r_in_valid;
  logic [WIDTH-1:0]           r_data;
  logic                       r_cfg_done;
  logic [FIR_RUN_CNT_W-1:0]   r_run_count;

  logic                       w_ready;
  logic                       w_xfer;
  logic                       w_tap_last;
  logic [CNT_W-1:0]           w_tap_next;

  // Ready depends only on state and cfg_start, so a restart never swallows a word.
  assign w_ready    = (r_state != ST_IDLE) && !cfg_start;
  assign w_xfer     = s_valid && w_ready;
  assign w_tap_last = (r_tap == LAST_TAP);
  assign w_tap_next = w_tap_last ? '0 : (r_tap + CNT_W'(1));

  // Sequencer FSM with registered strobes, data, tap counter and run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tap       <= '0;
      r_wind      <= 1'b0;
      r_load      <= 1'b0;
      r_in_valid  <= 1'b0;
      r_data      <= '0;
      r_cfg_done  <= 1'b0;
      r_run_count <= '0;
    end else begin
      // Strobes are single-cycle; they only rise on a transfer below.
      r_wind     <= 1'b0;
      r_load     <= 1'b0;
      r_in_valid <= 1'b0;

      if (cfg_start) begin
        // Restart wins over everything, including run_stop; nothing is accepted this cycle.
        r_state    <= ST_WIND;
        r_tap      <= '0;
        r_cfg_done <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            // Parked until a new configuration; run_stop has no effect here.
          end

          ST_WIND: begin
            if (w_xfer) begin
              r_wind <= 1'b1;
              r_data <= s_data;
              if (w_tap_last) begin
                r_state <= ST_LOAD;
                r_tap   <= '0;
              end else begin
                r_tap <= w_tap_next;
              end
            end
          end

          ST_LOAD: begin
            if (w_xfer) begin
              r_load <= 1'b1;
              r_data <= s_data;
              if (w_tap_last) begin
                r_state     <= ST_RUN;
                r_tap       <= '0;
                r_run_count <= '0;
                r_cfg_done  <= 1'b1;
              end else begin
                r_tap <= w_tap_next;
              end
            end
          end

          ST_RUN: begin
            // A word arriving with run_stop is still forwarded and counted.
            if (w_xfer) begin
              r_in_valid  <= 1'b1;
              r_data      <= s_data;
              r_tap       <= w_tap_next;
              r_run_count <= r_run_count + FIR_RUN_CNT_W'(1);
            end
            if (run_stop) begin
              r_state    <= ST_IDLE;
              r_cfg_done <= 1'b0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready   = w_ready;
  assign wind      = r_wind;
  assign load      = r_load;
  assign in_valid  = r_in_valid;
  assign data      = r_data;
  assign cfg_done  = r_cfg_done;
  assign run_count = r_run_count;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: vector table plus corner-case sequences.
module tb_fir_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic        run_stop;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        wind;
  logic        load;
  logic        in_valid;
  logic [15:0] data;
  logic        cfg_done;
  logic [15:0] run_count;

  int n_checks = 0;
  int n_err    = 0;

  fir_sequencer #(.TAPS(16), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .run_stop  (run_stop),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .wind      (wind),
    .load      (load),
    .in_valid  (in_valid),
    .data      (data),
    .cfg_done  (cfg_done),
    .run_count (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        rs;
    logic        v;
    logic [15:0] d;
    logic        e_rdy;
    logic        e_w;
    logic        e_l;
    logic        e_i;
    logic [15:0] e_d;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cs, rs, v, input logic [15:0] d,
                     input logic e_rdy, e_w, e_l, e_i, input logic [15:0] e_d,
                     input logic e_done, input logic [15:0] e_cnt);
    vec_t t;
    t.cs = cs; t.rs = rs; t.v = v; t.d = d;
    t.e_rdy = e_rdy; t.e_w = e_w; t.e_l = e_l; t.e_i = e_i;
    t.e_d = e_d; t.e_done = e_done; t.e_cnt = e_cnt;
    vq.push_back(t);
  endtask

  // One clock: drive at negedge, check s_ready before the edge, outputs 1ns after it.
  task automatic cyc(input logic cs, rs, v, input logic [15:0] d,
                     input logic e_rdy, e_w, e_l, e_i, input logic [15:0] e_d,
                     input logic e_done, input logic [15:0] e_cnt, input string tag);
    @(negedge clk);
    cfg_start = cs; run_stop = rs; s_valid = v; s_data = d;
    #1;
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    cfg_start = 1'b0; run_stop = 1'b0; s_valid = 1'b0;
    chk({tag, ".wind"},      32'(wind),      32'(e_w));
    chk({tag, ".load"},      32'(load),      32'(e_l));
    chk({tag, ".in_valid"},  32'(in_valid),  32'(e_i));
    chk({tag, ".data"},      32'(data),      32'(e_d));
    chk({tag, ".cfg_done"},  32'(cfg_done),  32'(e_done));
    chk({tag, ".run_count"}, 32'(run_count), 32'(e_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s_ready"},   32'(s_ready),   32'd0);
    chk({tag, ".wind"},      32'(wind),      32'd0);
    chk({tag, ".load"},      32'(load),      32'd0);
    chk({tag, ".in_valid"},  32'(in_valid),  32'd0);
    chk({tag, ".data"},      32'(data),      32'd0);
    chk({tag, ".cfg_done"},  32'(cfg_done),  32'd0);
    chk({tag, ".run_count"}, 32'(run_count), 32'd0);
  endtask

  // Hard stop if something wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    logic [15:0] last_d;

    // ---- Vector table: full config, streaming, run_stop ----
    add(0,0,0,16'h0000, 0,0,0,0,16'h0000, 0,16'd0);               // idle, nothing ready
    add(1,0,1,16'hDEAD, 0,0,0,0,16'h0000, 0,16'd0);               // start: not ready, word ignored
    for (int i = 1; i <= 16; i++)
      add(0,0,1,16'(i), 1,1,0,0,16'(i), 0,16'd0);                 // sample preload
    for (int i = 1; i <= 16; i++)
      add(0,0,1,16'(i), 1,0,1,0,16'(i), (i == 16),16'd0);         // weights; done after 32nd
    add(0,0,0,16'h0000, 1,0,0,0,16'd16, 1,16'd0);                 // gap in RUN
    for (int k = 0; k < 6; k++)
      add(0,0,1,16'h0100 + 16'(k), 1,0,0,1,16'h0100 + 16'(k), 1,16'(k + 1));
    add(0,0,0,16'h0000, 1,0,0,0,16'h0105, 1,16'd6);               // stall holds data/count
    add(0,1,1,16'h0200, 1,0,0,1,16'h0200, 0,16'd7);               // stop with transfer
    add(0,1,1,16'h0300, 0,0,0,0,16'h0200, 0,16'd7);               // stop ignored in IDLE
    add(0,0,1,16'h0301, 0,0,0,0,16'h0200, 0,16'd7);

    rst = 1'b1; cfg_start = 1'b0; run_stop = 1'b0; s_valid = 1'b0; s_data = 16'h0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i])
      cyc(vq[i].cs, vq[i].rs, vq[i].v, vq[i].d, vq[i].e_rdy, vq[i].e_w, vq[i].e_l,
          vq[i].e_i, vq[i].e_d, vq[i].e_done, vq[i].e_cnt, $sformatf("vec%0d", i));

    // ---- Alternating s_valid through WIND and LOAD ----
    cyc(1,0,0,16'h0, 0,0,0,0,16'h0200, 0,16'd7, "alt.start");
    last_d = 16'h0200;
    for (int k = 0; k < 64; k++) begin
      logic v;
      int   t;
      v = (k % 2 == 0);
      t = k / 2;
      done_cnt = v ? (t + 1) : ((k + 1) / 2);
      if (v) last_d = 16'h4000 + 16'(k);
      cyc(0,0,v,16'h4000 + 16'(k), 1, v && (t < 16), v && (t >= 16), 0, last_d,
          (done_cnt >= 32), (done_cnt >= 32) ? 16'd0 : 16'd7, $sformatf("alt%0d", k));
    end
    cyc(0,0,1,16'h0500, 1,0,0,1,16'h0500, 1,16'd1, "alt.run0");
    cyc(0,0,1,16'h0501, 1,0,0,1,16'h0501, 1,16'd2, "alt.run1");

    // ---- cfg_start with run_stop in RUN: restart wins ----
    cyc(1,1,1,16'h0600, 0,0,0,0,16'h0501, 0,16'd2, "both");
    for (int k = 0; k < 16; k++)
      cyc(0,0,1,16'h0700 + 16'(k), 1,1,0,0,16'h0700 + 16'(k), 0,16'd2, $sformatf("both.w%0d", k));

    // ---- Abort after 10 weight words, then a clean configuration ----
    for (int k = 0; k < 10; k++)
      cyc(0,0,1,16'h0800 + 16'(k), 1,0,1,0,16'h0800 + 16'(k), 0,16'd2, $sformatf("abort.l%0d", k));
    cyc(1,0,1,16'h0900, 0,0,0,0,16'h0809, 0,16'd2, "abort.start");
    for (int k = 0; k < 16; k++)
      cyc(0,0,1,16'h0A00 + 16'(k), 1,1,0,0,16'h0A00 + 16'(k), 0,16'd2, $sformatf("abort.w%0d", k));
    for (int k = 0; k < 16; k++)
      cyc(0,0,1,16'h0B00 + 16'(k), 1,0,1,0,16'h0B00 + 16'(k), (k == 15),
          (k == 15) ? 16'd0 : 16'd2, $sformatf("abort.l2_%0d", k));
    for (int k = 0; k < 3; k++)
      cyc(0,0,1,16'h0C00 + 16'(k), 1,0,0,1,16'h0C00 + 16'(k), 1,16'(k + 1), $sformatf("abort.r%0d", k));

    // ---- Asynchronous reset mid-WIND ----
    cyc(1,0,0,16'h0, 0,0,0,0,16'h0C02, 0,16'd3, "arst.start");
    for (int k = 0; k < 5; k++)
      cyc(0,0,1,16'h0D00 + 16'(k), 1,1,0,0,16'h0D00 + 16'(k), 0,16'd3, $sformatf("arst.w%0d", k));
    #1 rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    cyc(0,0,1,16'h0E00, 0,0,0,0,16'h0000, 0,16'd0, "arst.idle");
    cyc(1,0,0,16'h0, 0,0,0,0,16'h0000, 0,16'd0, "arst.restart");
    for (int k = 0; k < 16; k++)
      cyc(0,0,1,16'h0F00 + 16'(k), 1,1,0,0,16'h0F00 + 16'(k), 0,16'd0, $sformatf("arst.cw%0d", k));
    for (int k = 0; k < 16; k++)
      cyc(0,0,1,16'h0F80 + 16'(k), 1,0,1,0,16'h0F80 + 16'(k), (k == 15),16'd0, $sformatf("arst.cl%0d", k));
    cyc(0,0,0,16'h0, 1,0,0,0,16'h0F8F, 1,16'd0, "arst.done");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter TAPS, default 16, number of filter taps (sample words and weight words per configuration).
REQ-002 SHALL have parameter WIDTH, default 16, bit width of every data word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port cfg_start  input  1  one-cycle pulse that begins a new configuration.
REQ-006 SHALL have port run_stop  input  1  one-cycle pulse that ends streaming.
REQ-007 SHALL have port s_valid  input  1  upstream word valid.
REQ-008 SHALL have port s_ready  output  1  word accept; a transfer occurs when s_valid and s_ready are both high.
REQ-009 SHALL have port s_data  input  WIDTH  upstream word.
REQ-010 SHALL have port wind  output  1  strobe: data is a sample-preload word for the filter.
REQ-011 SHALL have port load  output  1  strobe: data is a weight word for the filter.
REQ-012 SHALL have port in_valid  output  1  strobe: data is a streaming sample for the filter.
REQ-013 SHALL have port data  output  WIDTH  registered word presented to the filter.
REQ-014 SHALL have port cfg_done  output  1  high while in RUN.
REQ-015 SHALL have port run_count  output  16  streaming samples forwarded since RUN was entered; wraps from 0xFFFF to 0.

Function
REQ-016 SHALL implement the FSM states IDLE, WIND, LOAD and RUN.
REQ-017 SHALL drive s_ready high in WIND, LOAD and RUN only, and force it low in any cycle where cfg_start=1.
REQ-018 SHALL, in any state, go to WIND on cfg_start=1 and clear the tap counter; a configuration in progress is aborted.
REQ-019 SHALL, per transfer in WIND, assert wind (only) for exactly one cycle on the next clock, with data equal to s_data; the tap counter increments.
REQ-020 SHALL, per transfer in LOAD, behave as REQ-019 but assert load.
REQ-021 SHALL, per transfer in RUN, behave as REQ-019 but assert in_valid, and increment run_count.
REQ-022 SHALL move WIND->LOAD on the transfer at tap count TAPS-1, and clear the counter.
REQ-023 SHALL move LOAD->RUN on the transfer at tap count TAPS-1, clear run_count, and assert cfg_done from the next cycle.
REQ-024 SHALL move RUN->IDLE on run_stop=1; a transfer in that same cycle is still forwarded and counted.
REQ-025 SHALL ignore run_stop in IDLE, WIND and LOAD.
REQ-026 SHALL let cfg_start win over run_stop when both are asserted.
REQ-027 SHALL keep wind, load and in_valid mutually exclusive; all three are low in cycles with no transfer.
REQ-028 SHALL hold data at its last value when no transfer occurs.
REQ-029 SHALL stall with no strobe and no counter change while s_valid=0; gaps of any length are legal.
REQ-030 SHALL give a fixed latency of 1 cycle from transfer to strobe, with no bubbles at a sustained 1 word/cycle.

Reset
REQ-031 SHALL, on rst=1, immediately clear: state=IDLE, s_ready=0, wind=0, load=0, in_valid=0, data=0, cfg_done=0, run_count=0, tap counter=0.
REQ-032 SHALL discard any partial configuration on reset mid-operation; a fresh cfg_start is required.

Structure
REQ-033 SHALL place TAPS/WIDTH defaults and the state enum type in shared package fir_pkg, which fir also uses.
REQ-034 SHALL need no sub-module; the FSM, tap counter and output registers stay in one module.

Verification
REQ-035 SHALL cover: cfg_start, then 32 words 1..16,1..16 back-to-back -> wind strobes carry 1..16, load strobes carry 1..16, cfg_done=1 on the cycle after the 32nd transfer.
REQ-036 SHALL cover: in RUN, 6 words 0x0100..0x0105 -> 6 in_valid pulses each 1 cycle later with matching data, run_count=6.
REQ-037 SHALL cover: s_valid toggled 1,0,1,0 during WIND -> strobes only on transfer cycles, FSM enters LOAD only after the 16th transfer.
REQ-038 SHALL cover: cfg_start after 10 words of LOAD -> state WIND, counter 0, s_ready=0 in the start cycle, then a full 32-word configuration succeeds.
REQ-039 SHALL cover: run_stop together with a transfer -> that word forwarded, then IDLE with s_ready=0 and cfg_done=0; run_stop and cfg_start together -> WIND.
REQ-040 SHALL cover: rst asserted mid-WIND, asynchronous to clk -> all outputs 0 before the next clock edge, and cfg_done stays 0 until a new configuration completes.
